// File: rtl/jstk_pkg.sv
// Shared PMOD JSTK protocol definitions: frame geometry, command prefix,
// byte order and responder FSM states. Also used by the joystick master.
package jstk_pkg;

    localparam int         JSTK_FRAME_BITS = 40;
    localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

    // Byte positions within a frame, in transmission order (byte 0 goes first)
    localparam int JSTK_BYTE_X_LO = 0;
    localparam int JSTK_BYTE_X_HI = 1;
    localparam int JSTK_BYTE_Y_LO = 2;
    localparam int JSTK_BYTE_Y_HI = 3;
    localparam int JSTK_BYTE_BTN  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } jstk_state_e;

    function automatic logic [JSTK_FRAME_BITS-1:0] jstk_build_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        logic [JSTK_FRAME_BITS-1:0] f;
        f = '0;
        f[(4-JSTK_BYTE_X_LO)*8 +: 8] = x[7:0];
        f[(4-JSTK_BYTE_X_HI)*8 +: 8] = {6'b0, x[9:8]};
        f[(4-JSTK_BYTE_Y_LO)*8 +: 8] = y[7:0];
        f[(4-JSTK_BYTE_Y_HI)*8 +: 8] = {6'b0, y[9:8]};
        f[(4-JSTK_BYTE_BTN)*8  +: 8] = {5'b0, btn};
        return f;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous SPI line with a history flop
// producing single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Chain resets to 0 so a line already low at reset release never looks like a fall
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a PMOD JSTK: serves local X/Y/buttons to a remote
// master and decodes its LED command byte. All SPI lines are oversampled.
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] data_x,
    input  logic [DATA_W-1:0] data_y,
    input  logic [2:0]        buttons,
    output logic [1:0]        led,
    output logic              cmd_valid,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [5:0] FRAME_BITS_C = 6'(JSTK_FRAME_BITS);
    localparam logic [5:0] CMD_LAST_C   = 6'd7;

    logic sclk_sync, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .rst_n_i (rst),
        .d_i     (sclk),
        .sync_o  (sclk_sync),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk     (clk),
        .rst_n_i (rst),
        .d_i     (cs_n),
        .sync_o  (cs_sync),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Normalise position inputs to the 10-bit protocol width
    logic [9:0] x10, y10;
    generate
        if (DATA_W >= 10) begin : g_trunc
            assign x10 = data_x[9:0];
            assign y10 = data_y[9:0];
        end else begin : g_ext
            assign x10 = {{(10-DATA_W){1'b0}}, data_x};
            assign y10 = {{(10-DATA_W){1'b0}}, data_y};
        end
    endgenerate

    logic [JSTK_FRAME_BITS-1:0] frame_d;
    logic [7:0]                 rx_d;

    jstk_state_e                state_q;
    logic [JSTK_FRAME_BITS-1:0] tx_q;
    logic [7:0]                 rx_q;
    logic [5:0]                 bit_cnt_q;
    logic                       miso_q, miso_oe_q;
    logic [1:0]                 led_q;
    logic                       cmd_valid_q, frame_done_q, frame_err_q;

    always_comb begin
        frame_d = jstk_build_frame(x10, y10, buttons);
        rx_d    = {rx_q[6:0], mosi_s};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            led_q        <= 2'b00;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tx_q      <= frame_d;
                        rx_q      <= '0;
                        bit_cnt_q <= '0;
                        miso_q    <= frame_d[JSTK_FRAME_BITS-1];
                        miso_oe_q <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect wins over any SCLK edge seen in the same cycle
                    if (cs_rise) begin
                        if (bit_cnt_q >= FRAME_BITS_C) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_q <= rx_d;
                        if (bit_cnt_q != '1) begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                        if (bit_cnt_q == CMD_LAST_C && rx_d[7:2] == JSTK_CMD_PREFIX) begin
                            led_q       <= rx_d[1:0];
                            cmd_valid_q <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt_q < FRAME_BITS_C) begin
                            tx_q   <= {tx_q[JSTK_FRAME_BITS-2:0], 1'b0};
                            miso_q <= tx_q[JSTK_FRAME_BITS-2];
                        end else begin
                            miso_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign miso       = miso_q;
    assign miso_oe    = miso_oe_q;
    assign led        = led_q;
    assign cmd_valid  = cmd_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

    // Synchronized levels are only needed for their edges here
    logic unused_sync;
    assign unused_sync = sclk_sync ^ cs_sync;

endmodule
